// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer
// Turns a UART byte stream into RGB565 pixels for a downstream FIFO.
// Each frame starts with the header 0x55 0xAA. It is followed by
// PIXELS_PER_FRAME pixels, each sent as a high byte and then a low byte.
// Optional feature: define PIXEL_PACK_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES idle cycles in the pixel phase.
module uart_pixel_packer #(
    parameter int PIXELS_PER_FRAME = 76800,
    parameter int TIMEOUT_CYCLES   = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_data,
    output logic        frame_active,
    output logic        frame_done,
    output logic        overflow
);

    localparam int CNT_W = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS_PER_FRAME - 1);

    localparam logic [7:0] SYNC0_BYTE = 8'h55;
    localparam logic [7:0] SYNC1_BYTE = 8'hAA;

    // Catch parameter values that would make the counters meaningless.
    if (PIXELS_PER_FRAME < 1) begin : g_bad_frame_len
        $error("uart_pixel_packer: PIXELS_PER_FRAME must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_pixel_packer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        WAIT_SYNC0,
        WAIT_SYNC1,
        PIX_HI,
        PIX_LO
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       hi_byte;

`ifdef PIXEL_PACK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] idle_cnt;
`endif

    // Header detection, pixel assembly, FIFO write strobe and frame status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_SYNC0;
            pix_cnt      <= '0;
            hi_byte      <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data    <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
`ifdef PIXEL_PACK_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
            if (rx_valid) begin
`ifdef PIXEL_PACK_TIMEOUT_EN
                idle_cnt <= '0;
`endif
                case (state)
                    WAIT_SYNC0: begin
                        if (rx_data == SYNC0_BYTE) state <= WAIT_SYNC1;
                    end
                    WAIT_SYNC1: begin
                        if (rx_data == SYNC1_BYTE) begin
                            state        <= PIX_HI;
                            pix_cnt      <= '0;
                            overflow     <= 1'b0;
                            frame_active <= 1'b1;
                        end else if (rx_data != SYNC0_BYTE) begin
                            state <= WAIT_SYNC0;
                        end
                    end
                    PIX_HI: begin
                        hi_byte <= rx_data;
                        state   <= PIX_LO;
                    end
                    PIX_LO: begin
                        // A pixel that cannot be written is still counted,
                        // so the frame keeps its length.
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            fifo_data  <= {hi_byte, rx_data};
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (pix_cnt == LAST_PIX) begin
                            state        <= WAIT_SYNC0;
                            pix_cnt      <= '0;
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                        end else begin
                            state   <= PIX_HI;
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    default: state <= WAIT_SYNC0;
                endcase
            end
`ifdef PIXEL_PACK_TIMEOUT_EN
            else if (state == PIX_HI || state == PIX_LO) begin
                // A stalled frame is dropped without a frame_done pulse.
                // Any half-received pixel is discarded with it.
                if (idle_cnt == IDLE_LAST) begin
                    state        <= WAIT_SYNC0;
                    frame_active <= 1'b0;
                    pix_cnt      <= '0;
                    idle_cnt     <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Testbench for uart_pixel_packer, built with PIXELS_PER_FRAME=2 and TIMEOUT_CYCLES=16.
// A scoreboard queue holds the expected FIFO writes. The monitor checks each
// write against the queue at the falling clock edge.
module tb_uart_pixel_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_data;
    logic        frame_active;
    logic        frame_done;
    logic        overflow;

    typedef struct {
        logic [15:0] data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   write_count = 0;

    uart_pixel_packer #(
        .PIXELS_PER_FRAME(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data),
        .frame_active(frame_active),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one byte for exactly one rising edge and return 1 time unit after that edge.
    task automatic send(input logic [7:0] b, input logic full);
        rx_data   = b;
        rx_valid  = 1'b1;
        fifo_full = full;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic done);
        exp_t e;
        e.data = d;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each FIFO write with the scoreboard, and flag any stray frame_done.
    always @(negedge clk) begin
        if (reset_n && fifo_wr_en) begin
            exp_t e;
            write_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {16'h0, fifo_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_data", {16'h0, fifo_data}, {16'h0, e.data});
                check("write_frame_done", {31'h0, frame_done}, {31'h0, e.done});
            end
        end else if (reset_n && frame_done) begin
            check("stray_frame_done", {31'h0, frame_done}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wc;

        // Reset state
        #12;
        check("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        check("rst_data", {16'h0, fifo_data}, 32'h0);
        check("rst_active", {31'h0, frame_active}, 32'h0);
        check("rst_done", {31'h0, frame_done}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-pixel frame
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        check("basic_active_after_hdr", {31'h0, frame_active}, 32'h1);
        send(8'h12, 1'b0);
        push(16'h1234, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        push(16'h5678, 1'b1);
        send(8'h78, 1'b0);
        check("basic_active_end", {31'h0, frame_active}, 32'h0);
        idle(2);
        check("basic_queue_drained", exp_q.size(), 32'h0);

        // Noise, then a repeated 0x55 before 0xAA
        send(8'h00, 1'b0);
        send(8'h55, 1'b0);
        send(8'h55, 1'b0);
        check("resync_active_pre_aa", {31'h0, frame_active}, 32'h0);
        send(8'hAA, 1'b0);
        check("resync_active_post_aa", {31'h0, frame_active}, 32'h1);
        send(8'hAB, 1'b0);
        push(16'hABCD, 1'b0);
        send(8'hCD, 1'b0);
        send(8'hEF, 1'b0);
        push(16'hEF01, 1'b1);
        send(8'h01, 1'b0);
        idle(2);
        check("resync_queue_drained", exp_q.size(), 32'h0);

        // Full FIFO during pixel 0
        check("ovf_clear_before", {31'h0, overflow}, 32'h0);
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h11, 1'b0);
        wc = write_count;
        send(8'h22, 1'b1);
        idle(1);
        check("ovf_no_write_pix0", write_count - wc, 32'h0);
        check("ovf_set", {31'h0, overflow}, 32'h1);
        send(8'h33, 1'b0);
        push(16'h3344, 1'b1);
        send(8'h44, 1'b0);
        idle(2);
        check("ovf_queue_drained", exp_q.size(), 32'h0);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        check("ovf_cleared_by_hdr", {31'h0, overflow}, 32'h0);

        // 0x55 0xAA inside the frame opened above are pixel data
        send(8'h55, 1'b0);
        push(16'h55AA, 1'b0);
        send(8'hAA, 1'b0);
        idle(1);
        check("data_sync_still_active", {31'h0, frame_active}, 32'h1);
        send(8'h66, 1'b0);
        push(16'h6677, 1'b1);
        send(8'h77, 1'b0);
        idle(2);
        check("data_sync_queue_drained", exp_q.size(), 32'h0);
        check("data_sync_active_end", {31'h0, frame_active}, 32'h0);

        // Reset in the middle of a frame
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h12, 1'b0);
        reset_n = 1'b0;
        #2;
        check("midrst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        check("midrst_data", {16'h0, fifo_data}, 32'h0);
        check("midrst_active", {31'h0, frame_active}, 32'h0);
        check("midrst_done", {31'h0, frame_done}, 32'h0);
        check("midrst_overflow", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wc = write_count;
        send(8'h34, 1'b0);
        idle(3);
        check("midrst_no_write", write_count - wc, 32'h0);
        check("midrst_still_idle", {31'h0, frame_active}, 32'h0);

        // Idle gap in the pixel phase
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h12, 1'b0);
        idle(15);
        check("idle15_active", {31'h0, frame_active}, 32'h1);
        idle(1);
`ifdef PIXEL_PACK_TIMEOUT_EN
        check("timeout_active", {31'h0, frame_active}, 32'h0);
        wc = write_count;
        send(8'h34, 1'b0);
        idle(3);
        check("timeout_no_write", write_count - wc, 32'h0);
`else
        check("no_timeout_active", {31'h0, frame_active}, 32'h1);
        push(16'h1234, 1'b0);
        send(8'h34, 1'b0);
        idle(2);
        check("no_timeout_queue_drained", exp_q.size(), 32'h0);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
